// File: rtl/sim_halt_monitor.sv
// sim_halt_monitor
// Run-control monitor for the single-cycle CPU simulation top.
//
// The monitor watches the retire stream for a stop condition:
//   - instruction limit
//   - PC match
//   - ecall / ebreak
//   - external request
//   - self-loop (optional)
//
// Once a stop condition fires it freezes the core, then walks the register
// file through the reg_sel/reg_data debug port. Each register value is
// streamed out as one valid/ready beat.
//
// Optional feature: define HALT_MON_STUCK_EN to compile the self-loop
// detector (cause 5). Without it, no stuck logic exists and cause 5 never
// appears.
module sim_halt_monitor #(
  parameter int              XLEN        = 32,
  parameter int              NREG        = 32,
  parameter int              CNT_W       = 32,
  parameter int unsigned     STOP_INSTR  = 200,
  parameter logic [XLEN-1:0] STOP_PC     = 32'hFFFF_FFFF,
  parameter int              STUCK_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  retire_pc,
  input  logic [31:0]      retire_instr,
  input  logic             stop_req,
  output logic             halt,
  output logic [4:0]       reg_sel,
  input  logic [XLEN-1:0]  reg_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_idx,
  output logic [XLEN-1:0]  dump_data,
  output logic             done,
  output logic [2:0]       cause,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [31:0]      ECALL_ENC  = 32'h0000_0073;
  localparam logic [31:0]      EBREAK_ENC = 32'h0010_0073;
  localparam logic [XLEN-1:0]  PC_OFF     = {XLEN{1'b1}};
  localparam logic [4:0]       LAST_IDX   = 5'(NREG - 1);
  localparam logic [CNT_W:0]   STOP_CNT   = (CNT_W+1)'(STOP_INSTR);

  localparam logic [2:0] C_NONE   = 3'd0;
  localparam logic [2:0] C_LIMIT  = 3'd1;
  localparam logic [2:0] C_PC     = 3'd2;
  localparam logic [2:0] C_ECALL  = 3'd3;
  localparam logic [2:0] C_EBREAK = 3'd4;
  localparam logic [2:0] C_STUCK  = 3'd5;
  localparam logic [2:0] C_EXT    = 3'd6;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_STOP = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        w_trig_cause;

  logic              r_halt;
  logic [2:0]        r_cause;
  logic [CNT_W-1:0]  r_instr_count;
  logic [CNT_W-1:0]  r_cycle_count;

  logic [4:0]        r_reg_sel;
  logic              r_dump_valid;
  logic [4:0]        r_dump_idx;
  logic [XLEN-1:0]   r_dump_data;
  logic              r_issued_all;
  logic              r_done;

  logic [CNT_W:0]    w_instr_inc;
  logic              w_hit_limit;
  logic              w_hit_pc;
  logic              w_hit_ecall;
  logic              w_hit_ebreak;
  logic              w_hit_stuck;
  logic              w_slot_free;
  logic              w_take;

  // The count including this retire is compared one bit wider, so a
  // saturated counter cannot alias back onto the limit.
  assign w_instr_inc  = {1'b0, r_instr_count} + 1'b1;

  assign w_hit_limit  = retire_valid && (STOP_INSTR != 0) && (w_instr_inc == STOP_CNT);
  assign w_hit_pc     = retire_valid && (STOP_PC != PC_OFF) && (retire_pc == STOP_PC);
  assign w_hit_ecall  = retire_valid && (retire_instr == ECALL_ENC);
  assign w_hit_ebreak = retire_valid && (retire_instr == EBREAK_ENC);

`ifdef HALT_MON_STUCK_EN
  localparam int STK_W = $clog2(STUCK_LIMIT + 1) + 1;

  logic [XLEN-1:0]  r_last_pc;
  logic [STK_W-1:0] r_stuck_cnt;
  logic             r_pc_seen;
  logic [STK_W-1:0] w_stuck_nxt;

  // The run length including the current retire.
  // It restarts at 1 whenever the PC changes.
  always_comb begin
    w_stuck_nxt = STK_W'(1);
    if (r_pc_seen && (retire_pc == r_last_pc)) begin
      w_stuck_nxt = (r_stuck_cnt == {STK_W{1'b1}}) ? r_stuck_cnt : r_stuck_cnt + 1'b1;
    end
  end

  assign w_hit_stuck = retire_valid && (w_stuck_nxt == STK_W'(STUCK_LIMIT));

  // Track the last retired PC and its repeat count.
  // Only retire cycles in RUN move the tracker.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_pc   <= '0;
      r_stuck_cnt <= '0;
      r_pc_seen   <= 1'b0;
    end else if ((r_state == S_RUN) && retire_valid) begin
      r_last_pc   <= retire_pc;
      r_stuck_cnt <= w_stuck_nxt;
      r_pc_seen   <= 1'b1;
    end
  end
`else
  // Self-loop detection is not built; this cause never fires.
  assign w_hit_stuck = 1'b0 & (STUCK_LIMIT != 0);
`endif

  assign w_slot_free = !r_dump_valid || dump_ready;
  assign w_take      = r_dump_valid && dump_ready;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and prioritised stop cause.
  // Only one cause is ever produced.
  always_comb begin
    w_state_nxt  = r_state;
    w_trig_cause = C_NONE;
    case (r_state)
      S_RUN: begin
        if (w_hit_ecall)       w_trig_cause = C_ECALL;
        else if (w_hit_ebreak) w_trig_cause = C_EBREAK;
        else if (w_hit_pc)     w_trig_cause = C_PC;
        else if (w_hit_stuck)  w_trig_cause = C_STUCK;
        else if (w_hit_limit)  w_trig_cause = C_LIMIT;
        else if (stop_req)     w_trig_cause = C_EXT;
        if (w_trig_cause != C_NONE) w_state_nxt = S_STOP;
      end
      S_STOP: w_state_nxt = S_DUMP;
      S_DUMP: begin
        if (w_take && (r_dump_idx == LAST_IDX)) w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_DONE;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Saturating instruction and cycle counters.
  // They advance only while running.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_instr_count <= '0;
      r_cycle_count <= '0;
    end else if (r_state == S_RUN) begin
      if (r_cycle_count != {CNT_W{1'b1}}) r_cycle_count <= r_cycle_count + 1'b1;
      if (retire_valid && (r_instr_count != {CNT_W{1'b1}})) r_instr_count <= r_instr_count + 1'b1;
    end
  end

  // Latch halt and the winning cause on the trigger cycle.
  // Both hold until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_halt  <= 1'b0;
      r_cause <= C_NONE;
    end else if ((r_state == S_RUN) && (w_trig_cause != C_NONE)) begin
      r_halt  <= 1'b1;
      r_cause <= w_trig_cause;
    end
  end

  // Register-file walk through a one-entry output slot.
  // A new beat loads whenever the slot is empty or is being drained.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_reg_sel    <= '0;
      r_dump_valid <= 1'b0;
      r_dump_idx   <= '0;
      r_dump_data  <= '0;
      r_issued_all <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_STOP: begin
          r_reg_sel    <= '0;
          r_issued_all <= 1'b0;
        end
        S_DUMP: begin
          if (w_slot_free && !r_issued_all) begin
            r_dump_valid <= 1'b1;
            r_dump_idx   <= r_reg_sel;
            r_dump_data  <= (r_reg_sel == 5'd0) ? '0 : reg_data;
            if (r_reg_sel == LAST_IDX) r_issued_all <= 1'b1;
            else                       r_reg_sel    <= r_reg_sel + 1'b1;
          end else if (w_take) begin
            r_dump_valid <= 1'b0;
          end
          if (w_take && (r_dump_idx == LAST_IDX)) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halt        = r_halt;
  assign cause       = r_cause;
  assign instr_count = r_instr_count;
  assign cycle_count = r_cycle_count;
  assign reg_sel     = r_reg_sel;
  assign dump_valid  = r_dump_valid;
  assign dump_idx    = r_dump_idx;
  assign dump_data   = r_dump_data;
  assign done        = r_done;

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Bench for sim_halt_monitor.
//
// A cycle-level reference model of the run/stop/dump rules is checked
// against the DUT on every falling edge. Directed scenarios add literal
// spot checks on top of that.
//
// Honours HALT_MON_STUCK_EN the same way the design does.
module tb_sim_halt_monitor;

  localparam int          NREG = 32;
  localparam int          CW   = 8;
  localparam int          SI   = 200;
  localparam logic [31:0] SPC  = 32'h0000_0040;
  localparam int          SL   = 8;
  localparam int          CMAX = 255;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JSELF  = 32'h0000_006F;

`ifdef HALT_MON_STUCK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          retire_valid = 1'b0;
  logic [31:0]   retire_pc = '0;
  logic [31:0]   retire_instr = '0;
  logic          stop_req = 1'b0;
  logic          dump_ready = 1'b1;
  logic          halt;
  logic [4:0]    reg_sel;
  logic [31:0]   reg_data;
  logic          dump_valid;
  logic [4:0]    dump_idx;
  logic [31:0]   dump_data;
  logic          done;
  logic [2:0]    cause;
  logic [CW-1:0] instr_count;
  logic [CW-1:0] cycle_count;

  logic [31:0]   rf [NREG];
  longint        got [NREG];
  int            n_total = 0;
  int            n_bad = 0;

  assign reg_data = rf[reg_sel];

  always #5 clk = ~clk;

  sim_halt_monitor #(
    .XLEN(32), .NREG(NREG), .CNT_W(CW), .STOP_INSTR(SI),
    .STOP_PC(SPC), .STUCK_LIMIT(SL)
  ) dut (
    .clk(clk), .rstn(rstn),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .stop_req(stop_req),
    .halt(halt),
    .reg_sel(reg_sel), .reg_data(reg_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data),
    .done(done), .cause(cause),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Model state:
  //   m_halt / m_cause  -- stopped yet, and why
  //   m_icnt / m_ccnt   -- retires and run cycles
  //   m_age             -- edges since the stop
  //   m_next            -- next register index the consumer should see
  //   m_run             -- length of the current same-PC retire run
  bit          m_halt, n_halt;
  int          m_cause, n_cause, m_icnt, n_icnt, m_ccnt, n_ccnt;
  int          m_age, n_age, m_next, n_next, m_run, n_run;
  logic [31:0] m_last, n_last;
  int          c;
  bit          exp_valid;

  always_comb begin
    n_halt = m_halt; n_cause = m_cause; n_icnt = m_icnt; n_ccnt = m_ccnt;
    n_age = m_age; n_next = m_next; n_run = m_run; n_last = m_last;
    c = 0;
    if (!m_halt) begin
      if (retire_valid) begin
        n_run  = (m_run != 0 && retire_pc == m_last) ? m_run + 1 : 1;
        n_last = retire_pc;
        if (retire_instr == ECALL)                c = 3;
        else if (retire_instr == EBREAK)          c = 4;
        else if (retire_pc == SPC)                c = 2;
        else if (STK && n_run == SL)              c = 5;
        else if (m_icnt + 1 == SI)                c = 1;
        n_icnt = (m_icnt >= CMAX) ? CMAX : m_icnt + 1;
      end
      if (c == 0 && stop_req) c = 6;
      n_ccnt = (m_ccnt >= CMAX) ? CMAX : m_ccnt + 1;
      if (c != 0) begin
        n_halt = 1'b1; n_cause = c; n_age = 0;
      end
    end else begin
      // Stop cycle, then first dump cycle loads beat 0.
      // Beats are visible from the second cycle after halt onward.
      if (m_age < 2) n_age = m_age + 1;
      if (m_age >= 2 && m_next < NREG && dump_ready) n_next = m_next + 1;
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_halt <= 1'b0; m_cause <= 0; m_icnt <= 0; m_ccnt <= 0;
      m_age <= 0; m_next <= 0; m_run <= 0; m_last <= '0;
    end else begin
      m_halt <= n_halt; m_cause <= n_cause; m_icnt <= n_icnt; m_ccnt <= n_ccnt;
      m_age <= n_age; m_next <= n_next; m_run <= n_run; m_last <= n_last;
    end
  end

  assign exp_valid = m_halt && (m_age >= 2) && (m_next < NREG);

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("halt", halt, m_halt);
    chk("cause", cause, m_cause);
    chk("instr_count", instr_count, m_icnt);
    chk("cycle_count", cycle_count, m_ccnt);
    chk("dump_valid", dump_valid, exp_valid);
    chk("done", done, (m_next == NREG));
    if (exp_valid) begin
      chk("dump_idx", dump_idx, m_next);
      chk("dump_data", dump_data, (m_next == 0) ? 64'd0 : longint'(rf[m_next]));
      got[m_next] <= dump_data;
    end
    if (!rstn) begin
      chk("rst_reg_sel", reg_sel, 0);
      chk("rst_dump_idx", dump_idx, 0);
      chk("rst_dump_data", dump_data, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input bit hold_req);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    retire_valid = 1'b0;
    stop_req = hold_req;
    dump_ready = 1'b1;
    #1;
    chk("rst_halt", halt, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_cause", cause, 0);
    chk("rst_icnt", instr_count, 0);
    chk("rst_ccnt", cycle_count, 0);
    chk("rst_data", dump_data, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic ret(input logic [31:0] pc, input logic [31:0] ins);
    @(negedge clk);
    retire_valid = 1'b1;
    retire_pc = pc;
    retire_instr = ins;
  endtask

  task automatic idle();
    @(negedge clk);
    retire_valid = 1'b0;
  endtask

  task automatic run_dump(input bit toggle, input bit noise);
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      dump_ready = toggle ? ~dump_ready : 1'b1;
      if (noise) begin
        retire_valid = 1'b1;
        retire_pc = SPC;
        retire_instr = ECALL;
        stop_req = 1'b1;
      end
    end
    chk("dump_finished", done, 1);
    retire_valid = 1'b0;
    stop_req = 1'b0;
    dump_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      rf[i] = 32'hA000_0000 + i;
      got[i] = -1;
    end
    #1;
    rstn = 1'b0;
    do_reset(1'b0);

    // Limit stop after 200 retires.
    // Retires and stop requests during the dump must be ignored.
    for (int i = 0; i < SI; i++) begin
      ret(32'h1000 + 4 * i, NOP);
      if (i == SI - 1) chk("lim_no_halt_yet", halt, 0);
    end
    idle();
    chk("lim_halt", halt, 1);
    chk("lim_cause", cause, 1);
    chk("lim_icnt", instr_count, 200);
    run_dump(1'b0, 1'b1);
    chk("lim_cause_hold", cause, 1);
    chk("lim_icnt_hold", instr_count, 200);
    chk("lim_beat31", got[31], 64'hA000_001F);

    // ecall coinciding with the limit retire: ecall wins.
    do_reset(1'b0);
    for (int i = 0; i < SI; i++) ret(32'h1000 + 4 * i, (i == SI - 1) ? ECALL : NOP);
    idle();
    chk("ecall_cause", cause, 3);
    chk("ecall_icnt", instr_count, 200);
    run_dump(1'b0, 1'b0);

    // PC match with retire bubbles, then a dump under toggling backpressure.
    do_reset(1'b0);
    for (int i = 0; i < NREG; i++) rf[i] = 3 * i;
    rf[0] = 32'hDEAD_BEEF;
    for (int i = 0; i <= 16; i++) begin
      ret(4 * i, NOP);
      if (i % 4 == 3) idle();
    end
    idle();
    chk("pc_cause", cause, 2);
    chk("pc_icnt", instr_count, 17);
    run_dump(1'b1, 1'b0);
    chk("bp_beat0", got[0], 0);
    chk("bp_beat5", got[5], 15);
    chk("bp_beat31", got[31], 93);

    // ebreak at the match PC: ebreak wins.
    // Reset at beat 10 with stop_req held through reset.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) ret(32'h100 + 4 * i, NOP);
    ret(SPC, EBREAK);
    idle();
    chk("ebreak_cause", cause, 4);
    chk("ebreak_icnt", instr_count, 4);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dump_valid && dump_idx == 5'd10) break;
    end
    chk("reached_beat10", dump_idx, 10);
    do_reset(1'b1);
    @(negedge clk);
    chk("ext_halt", halt, 1);
    chk("ext_cause", cause, 6);
    chk("ext_icnt", instr_count, 0);
    stop_req = 1'b0;
    run_dump(1'b0, 1'b0);

    // Self-loop at 0x24.
    do_reset(1'b0);
    ret(32'h20, NOP);
    for (int k = 0; k < 220; k++) begin
      if (halt) break;
      ret(32'h24, JSELF);
    end
    idle();
    chk("stuck_cause", cause, STK ? 5 : 1);
    chk("stuck_icnt", instr_count, STK ? 9 : 200);
    run_dump(1'b0, 1'b0);

    // Cycle counter saturation.
    // PC match beats an external request on the same cycle.
    do_reset(1'b0);
    repeat (300) idle();
    chk("sat_ccnt", cycle_count, 255);
    chk("sat_icnt", instr_count, 0);
    chk("sat_halt", halt, 0);
    ret(SPC, NOP);
    stop_req = 1'b1;
    idle();
    stop_req = 1'b0;
    chk("prio_cause", cause, 2);
    chk("prio_icnt", instr_count, 1);
    run_dump(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
